// File: rtl/lcd_layer_mixer.sv
// Two-stage pixel compositor: tile palette colour, N_OVL priority overlays with per-frame blink, aligned syncs.
// Define LCD_MIXER_TEST_PATTERN_EN to add the test_mode input and the 8-bar column test pattern.
module lcd_layer_mixer #(
    parameter int TILE_BITS    = 2,
    parameter int N_OVL        = 2,
    parameter int CW           = 8,
    parameter int BLINK_FRAMES = 16,
`ifdef LCD_MIXER_TEST_PATTERN_EN
    parameter int BAR_W        = 100,
`endif
    localparam int NTILE = 2 ** TILE_BITS,
    localparam int NPAL  = NTILE + N_OVL,
    localparam int PAW   = $clog2(NPAL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 de_in,
    input  logic                 hs_in,
    input  logic                 vs_in,
    input  logic                 frame_sync,
    input  logic [TILE_BITS-1:0] tile,
    input  logic [N_OVL-1:0]     ovl,
    input  logic [N_OVL-1:0]     blink_en,
`ifdef LCD_MIXER_TEST_PATTERN_EN
    input  logic                 test_mode,
`endif
    input  logic                 pal_we,
    input  logic [PAW-1:0]       pal_addr,
    input  logic [3*CW-1:0]      pal_wdata,
    output logic [CW-1:0]        R,
    output logic [CW-1:0]        G,
    output logic [CW-1:0]        B,
    output logic                 de_out,
    output logic                 hs_out,
    output logic                 vs_out
);

    function automatic logic [3*CW-1:0] pal_default(input int idx);
        logic [23:0] c;
        if (idx < NTILE) begin
            case (idx)
                0:       c = 24'hFFFFFF;
                1:       c = 24'h08FF00;
                2:       c = 24'h0000FF;
                3:       c = 24'hFF0000;
                default: c = 24'h000000;
            endcase
        end else begin
            case (idx - NTILE)
                0:       c = 24'hFF8800;
                1:       c = 24'h0808FF;
                default: c = 24'hFFFFFF;
            endcase
        end
        return {c[23 -: CW], c[15 -: CW], c[7 -: CW]};
    endfunction

    logic [3*CW-1:0]  pal_q [NPAL];
    logic [3*CW-1:0]  pal_d [NPAL];
    logic [7:0]       blink_cnt_q, blink_cnt_d;
    logic             phase_q, phase_d;
    logic             de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic [3*CW-1:0]  tcol1_q, tcol1_d;
    logic [N_OVL-1:0] ovl1_q, ovl1_d;
    logic [3*CW-1:0]  rgb_q, rgb_d;
    logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d;
`ifdef LCD_MIXER_TEST_PATTERN_EN
    logic [10:0]      col_q, col_d;
    logic             tm1_q, tm1_d;
    logic [3*CW-1:0]  bar1_q, bar1_d;
    logic [2:0]       bar_idx;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pal_d = pal_q;
        if (pal_we && (int'(pal_addr) < NPAL))
            pal_d[pal_addr] = pal_wdata;

        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (frame_sync) begin
            if (blink_cnt_q == 8'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_d     = !phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end

        // S1: the tile read sees the palette before this edge's write.
        de1_d   = de_in;
        hs1_d   = hs_in;
        vs1_d   = vs_in;
        tcol1_d = pal_q[tile];
        for (int i = 0; i < N_OVL; i++)
            ovl1_d[i] = ovl[i] && !(blink_en[i] && !phase_q);
`ifdef LCD_MIXER_TEST_PATTERN_EN
        col_d   = de_in ? col_q + 11'd1 : '0;
        bar_idx = 3'((int'(col_q) / BAR_W) % 8);
        tm1_d   = test_mode;
        bar1_d  = {{CW{bar_idx[2]}}, {CW{bar_idx[1]}}, {CW{bar_idx[0]}}};
`endif

        // S2: ascending scan so the highest-index visible overlay wins.
        rgb_d = tcol1_q;
        for (int i = 0; i < N_OVL; i++)
            if (ovl1_q[i]) rgb_d = pal_q[NTILE + i];
`ifdef LCD_MIXER_TEST_PATTERN_EN
        if (tm1_q) rgb_d = bar1_q;
`endif
        if (!de1_q) rgb_d = '0;
        de_d = de1_q;
        hs_d = hs1_q;
        vs_d = vs1_q;
    end

    // NOTE: sequential state uses non-blocking assignments only; the palette is reset because it must reload its defaults.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NPAL; i++)
                pal_q[i] <= pal_default(i);
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            // Sync copies idle high so hs_out/vs_out stay inactive as reset releases.
            de1_q       <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            tcol1_q     <= '0;
            ovl1_q      <= '0;
            rgb_q       <= '0;
            de_q        <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
`ifdef LCD_MIXER_TEST_PATTERN_EN
            col_q       <= '0;
            tm1_q       <= 1'b0;
            bar1_q      <= '0;
`endif
        end else begin
            pal_q       <= pal_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            de1_q       <= de1_d;
            hs1_q       <= hs1_d;
            vs1_q       <= vs1_d;
            tcol1_q     <= tcol1_d;
            ovl1_q      <= ovl1_d;
            rgb_q       <= rgb_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
`ifdef LCD_MIXER_TEST_PATTERN_EN
            col_q       <= col_d;
            tm1_q       <= tm1_d;
            bar1_q      <= bar1_d;
`endif
        end
    end

    assign R      = rgb_q[3*CW-1 -: CW];
    assign G      = rgb_q[2*CW-1 -: CW];
    assign B      = rgb_q[CW-1:0];
    assign de_out = de_q;
    assign hs_out = hs_q;
    assign vs_out = vs_q;

endmodule

// File: tb/tb_lcd_layer_mixer.sv
// Self-checking bench for lcd_layer_mixer: directed scenarios plus randomized traffic against a behavioural model.
module tb_lcd_layer_mixer;

    localparam int TILE_BITS    = 2;
    localparam int N_OVL        = 2;
    localparam int CW           = 8;
    localparam int BLINK_FRAMES = 16;
    localparam int BAR_W        = 100;
    localparam int NTILE        = 4;
    localparam int NPAL         = 6;
    localparam int PAW          = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 de_in, hs_in, vs_in, frame_sync;
    logic [TILE_BITS-1:0] tile;
    logic [N_OVL-1:0]     ovl, blink_en;
    logic                 test_mode;
    logic                 pal_we;
    logic [PAW-1:0]       pal_addr;
    logic [3*CW-1:0]      pal_wdata;
    logic [CW-1:0]        R, G, B;
    logic                 de_out, hs_out, vs_out;

    always #5 clk = ~clk;

    lcd_layer_mixer #(
        .TILE_BITS(TILE_BITS), .N_OVL(N_OVL), .CW(CW), .BLINK_FRAMES(BLINK_FRAMES)
`ifdef LCD_MIXER_TEST_PATTERN_EN
        , .BAR_W(BAR_W)
`endif
    ) dut (
        .clk(clk), .rst(rst), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
        .frame_sync(frame_sync), .tile(tile), .ovl(ovl), .blink_en(blink_en),
`ifdef LCD_MIXER_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
        .R(R), .G(G), .B(B), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: palette array, pulse count since reset, one pending pixel and the expected outputs.
    logic [23:0]    mpal [NPAL];
    int             pulses, mcol;
    bit             m_de, m_hs, m_vs, m_tm;
    logic [23:0]    m_tcol, m_bar;
    bit [N_OVL-1:0] m_ov;
    logic [23:0]    e_rgb;
    bit             e_de, e_hs, e_vs;

    task automatic model_reset();
        logic [23:0] defs [NPAL];
        defs = '{24'hFFFFFF, 24'h08FF00, 24'h0000FF, 24'hFF0000, 24'hFF8800, 24'h0808FF};
        for (int i = 0; i < NPAL; i++) mpal[i] = defs[i];
        pulses = 0; mcol = 0;
        m_de = 0; m_hs = 1; m_vs = 1; m_tm = 0; m_tcol = '0; m_bar = '0; m_ov = '0;
        e_rgb = '0; e_de = 0; e_hs = 1; e_vs = 1;
    endtask

    // Applies the rules for the clock edge about to happen, using the inputs currently driven.
    task automatic model_edge();
        logic [23:0] c;
        int          idx;
        bit          visible;
        if (!rst) begin
            model_reset();
            return;
        end
        c = m_tcol;
        for (int i = N_OVL - 1; i >= 0; i--)
            if (m_ov[i]) begin
                c = mpal[NTILE + i];
                break;
            end
        if (m_tm) c = m_bar;
        if (!m_de) c = '0;
        e_rgb = c; e_de = m_de; e_hs = m_hs; e_vs = m_vs;

        visible = ((pulses / BLINK_FRAMES) % 2) == 0;
        m_de = de_in; m_hs = hs_in; m_vs = vs_in;
        m_tcol = mpal[tile];
        for (int i = 0; i < N_OVL; i++)
            m_ov[i] = ovl[i] && !(blink_en[i] && !visible);
`ifdef LCD_MIXER_TEST_PATTERN_EN
        idx   = (mcol / BAR_W) % 8;
        m_bar = {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
        m_tm  = test_mode;
        mcol  = de_in ? mcol + 1 : 0;
`else
        idx  = 0;
        m_tm = 0;
`endif
        if (pal_we && int'(pal_addr) < NPAL) mpal[pal_addr] = pal_wdata;
        if (frame_sync) pulses++;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("rgb", {8'h00, R, G, B}, {8'h00, e_rgb});
        check("de_out", {31'd0, de_out}, {31'd0, e_de});
        check("hs_out", {31'd0, hs_out}, {31'd0, e_hs});
        check("vs_out", {31'd0, vs_out}, {31'd0, e_vs});
    endtask

    task automatic pixel(input logic de, input logic [1:0] t, input logic [1:0] o);
        de_in = de; tile = t; ovl = o;
    endtask

    initial begin
        rst = 1'b0; de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1; frame_sync = 1'b0;
        tile = '0; ovl = '0; blink_en = '0; test_mode = 1'b0;
        pal_we = 1'b0; pal_addr = '0; pal_wdata = '0;

        // Reset held for three clocks, with a frame_sync pulse that must be ignored.
        frame_sync = 1'b1;
        repeat (3) cycle();
        frame_sync = 1'b0;
        check("rst_rgb", {8'h00, R, G, B}, 32'h0);
        check("rst_de", {31'd0, de_out}, 32'd0);
        check("rst_hs", {31'd0, hs_out}, 32'd1);
        check("rst_vs", {31'd0, vs_out}, 32'd1);

        rst = 1'b1;
        pixel(1'b1, 2'd3, 2'b00);
        cycle();
        cycle();
        check("tile3", {8'h00, R, G, B}, 32'hFF0000);

        // Sync pulse repeats two clocks later.
        hs_in = 1'b0; vs_in = 1'b0;
        cycle();
        hs_in = 1'b1; vs_in = 1'b1;
        cycle();
        check("hs_delay", {31'd0, hs_out}, 32'd0);
        check("vs_delay", {31'd0, vs_out}, 32'd0);
        cycle();
        check("hs_release", {31'd0, hs_out}, 32'd1);

        pixel(1'b1, 2'd1, 2'b11);
        cycle(); cycle();
        check("prio_ovl1", {8'h00, R, G, B}, 32'h0808FF);
        pixel(1'b1, 2'd1, 2'b01);
        cycle(); cycle();
        check("prio_ovl0", {8'h00, R, G, B}, 32'hFF8800);
        pixel(1'b0, 2'd2, 2'b11);
        cycle(); cycle();
        check("blank", {8'h00, R, G, B}, 32'h0);

        // Palette write: same-cycle read sees old value, next cycle sees new value.
        pixel(1'b1, 2'd0, 2'b00);
        pal_we = 1'b1; pal_addr = 3'd0; pal_wdata = 24'h123456;
        cycle();
        pal_we = 1'b0;
        cycle();
        check("rbw_old", {8'h00, R, G, B}, 32'hFFFFFF);
        cycle();
        check("rbw_new", {8'h00, R, G, B}, 32'h123456);

        pal_we = 1'b1; pal_addr = 3'd6; pal_wdata = 24'h000000;
        cycle();
        pal_addr = 3'd7;
        cycle();
        pal_we = 1'b0;
        for (int t = 0; t < NTILE; t++) begin
            pixel(1'b1, 2'(t), 2'b00);
            cycle();
        end
        pixel(1'b1, 2'd1, 2'b10);
        cycle(); cycle();
        check("oor_ovl1", {8'h00, R, G, B}, 32'h0808FF);

        // Mid-frame reset reloads the palette defaults.
        rst = 1'b0; frame_sync = 1'b1;
        cycle();
        rst = 1'b1; frame_sync = 1'b0;
        check("midrst_rgb", {8'h00, R, G, B}, 32'h0);
        pixel(1'b1, 2'd0, 2'b00);
        cycle(); cycle();
        check("reload_t0", {8'h00, R, G, B}, 32'hFFFFFF);

        // Blink: overlay 0 hidden between the 16th and 32nd pulse.
        pixel(1'b1, 2'd0, 2'b01);
        blink_en = 2'b01;
        cycle(); cycle();
        check("blink_p0", {8'h00, R, G, B}, 32'hFF8800);
        for (int p = 1; p <= 32; p++) begin
            frame_sync = 1'b1;
            cycle();
            frame_sync = 1'b0;
            cycle(); cycle();
            check($sformatf("blink_p%0d", p), {8'h00, R, G, B},
                  (((p / 16) % 2) == 0) ? 32'hFF8800 : 32'hFFFFFF);
            if (p == 20) begin
                ovl = 2'b10;
                cycle(); cycle();
                check("blink_ovl1", {8'h00, R, G, B}, 32'h0808FF);
                ovl = 2'b01;
                cycle();
            end
        end
        blink_en = 2'b00;

`ifdef LCD_MIXER_TEST_PATTERN_EN
        // Test pattern over an 800-pixel line, with tile/overlay inputs that must be ignored.
        pixel(1'b0, 2'd2, 2'b11);
        test_mode = 1'b1;
        cycle();
        for (int k = 0; k <= 801; k++) begin
            de_in = (k < 800);
            cycle();
            if (k == 1)   check("bar_px0",   {8'h00, R, G, B}, 32'h000000);
            if (k == 101) check("bar_px100", {8'h00, R, G, B}, 32'h0000FF);
            if (k == 200) check("bar_px199", {8'h00, R, G, B}, 32'h0000FF);
            if (k == 701) check("bar_px700", {8'h00, R, G, B}, 32'hFFFFFF);
            if (k == 800) check("bar_px799", {8'h00, R, G, B}, 32'hFFFFFF);
        end
        test_mode = 1'b0;
`endif

        // Randomized traffic, including palette writes, blink and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 399) != 0);
            de_in      = ($urandom_range(0, 3) != 0);
            hs_in      = ($urandom_range(0, 15) != 0);
            vs_in      = ($urandom_range(0, 31) != 0);
            frame_sync = ($urandom_range(0, 5) == 0);
            tile       = 2'($urandom);
            ovl        = 2'($urandom);
            blink_en   = 2'($urandom);
            pal_we     = ($urandom_range(0, 7) == 0);
            pal_addr   = 3'($urandom);
            pal_wdata  = 24'($urandom);
`ifdef LCD_MIXER_TEST_PATTERN_EN
            test_mode  = ($urandom_range(0, 3) == 0);
`endif
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
